// File: rtl/cam_table_pkg.sv
// Shared definitions for the CAM table engine.
// Holds the default geometry, the FSM state encoding and the learn-target
// classification used when a learn scan finishes.
package cam_table_pkg;

  localparam int DEF_KEY_WIDTH  = 48;
  localparam int DEF_PORT_WIDTH = 4;
  localparam int DEF_DEPTH      = 16;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WRITE,
    RESPOND
  } state_t;

  // What a learn does to its target entry once the scan has picked it.
  typedef enum logic [1:0] {
    TGT_UPDATE,  // key already present: overwrite its port
    TGT_FREE,    // lowest free slot: entry_count grows
    TGT_EVICT    // table full: replace at the round-robin pointer
  } tgt_kind_t;

endpackage

// File: rtl/cam_table_if.sv
// Request/response bundle of the CAM table engine.
//   master : requester side (drives lookup/learn requests and flush)
//   slave  : engine side (drives readies, lookup result and entry_count)
// Signals:
//   lookup_valid/lookup_ready/lookup_key       lookup request handshake
//   learn_valid/learn_ready/learn_key/port     learn request handshake
//   flush                                      clear every entry
//   result_valid/result_hit/result_port        one-cycle lookup completion
//   entry_count                                number of valid entries
interface cam_table_if
  import cam_table_pkg::*;
#(
  parameter int KEY_WIDTH  = DEF_KEY_WIDTH,
  parameter int PORT_WIDTH = DEF_PORT_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic                  lookup_valid;
  logic                  lookup_ready;
  logic [KEY_WIDTH-1:0]  lookup_key;
  logic                  learn_valid;
  logic                  learn_ready;
  logic [KEY_WIDTH-1:0]  learn_key;
  logic [PORT_WIDTH-1:0] learn_port;
  logic                  flush;
  logic                  result_valid;
  logic                  result_hit;
  logic [PORT_WIDTH-1:0] result_port;
  logic [ADDR_WIDTH:0]   entry_count;

  modport master (
    output lookup_valid, lookup_key, learn_valid, learn_key, learn_port, flush,
    input  lookup_ready, learn_ready, result_valid, result_hit, result_port,
           entry_count
  );

  modport slave (
    input  lookup_valid, lookup_key, learn_valid, learn_key, learn_port, flush,
    output lookup_ready, learn_ready, result_valid, result_hit, result_port,
           entry_count
  );

endinterface

// File: rtl/cam_table_ram.sv
// Simple two-port RAM (one write port, one read port) with a registered
// read, written so synthesis maps it to block RAM. Contents are never reset.
//   clk      : clock
//   we       : write enable
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address (data appears one cycle later)
//   rd_data  : registered read data
module cam_table_ram #(
  parameter int DATA_WIDTH = 52,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cam_table_engine.sv
// Sequential-scan CAM for MAC learning: lookups return the port stored for a
// key, learns insert or update an entry. Each request scans the table one
// entry per cycle through a registered-read RAM; the per-entry valid bits
// live in flops so flush/reset can clear the table in one cycle.
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : cam_table_if slave (request handshakes, flush, result, entry_count)
module cam_table_engine
  import cam_table_pkg::*;
#(
  parameter int KEY_WIDTH  = DEF_KEY_WIDTH,
  parameter int PORT_WIDTH = DEF_PORT_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input logic        clk,
  input logic        rst,
  cam_table_if.slave bus
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int DATA_WIDTH = KEY_WIDTH + PORT_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   FULL = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                state;
  logic                  op_learn;
  logic [KEY_WIDTH-1:0]  key_q;
  logic [PORT_WIDTH-1:0] port_q;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  rd_done;
  logic                  cmp_vld;
  logic [ADDR_WIDTH-1:0] cmp_idx;
  logic                  free_found;
  logic [ADDR_WIDTH-1:0] free_idx;
  logic [ADDR_WIDTH-1:0] tgt_idx;
  tgt_kind_t             tgt_kind;
  logic [ADDR_WIDTH-1:0] repl_ptr;
  logic [DEPTH-1:0]      valid;
  logic [ADDR_WIDTH:0]   count;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  idle_ok;
  logic                  learn_acc;
  logic                  lookup_acc;
  logic                  cmp_hit;
  logic                  cur_free;
  logic                  scan_end;
  logic [KEY_WIDTH-1:0]  rd_key;
  logic [PORT_WIDTH-1:0] rd_port;

  // Readies are combinational so learn can win over lookup in the same cycle.
  assign idle_ok         = (state == IDLE) && !bus.flush && !rst;
  assign bus.learn_ready  = idle_ok;
  assign bus.lookup_ready = idle_ok && !bus.learn_valid;
  assign learn_acc        = bus.learn_valid && bus.learn_ready;
  assign lookup_acc       = bus.lookup_valid && bus.lookup_ready;
  assign bus.entry_count  = count;

  assign rd_key  = rd_data[DATA_WIDTH-1:PORT_WIDTH];
  assign rd_port = rd_data[PORT_WIDTH-1:0];

  // rd_data holds entry cmp_idx this cycle; valid bits gate stale RAM data.
  assign cmp_hit  = cmp_vld && valid[cmp_idx] && (rd_key == key_q);
  assign cur_free = cmp_vld && !valid[cmp_idx];
  assign scan_end = cmp_vld && (cmp_idx == LAST);

  cam_table_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .we     ((state == WRITE) && !bus.flush),
    .wr_addr(tgt_idx),
    .wr_data({key_q, port_q}),
    .rd_addr(rd_idx),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      op_learn         <= 1'b0;
      key_q            <= '0;
      port_q           <= '0;
      rd_idx           <= '0;
      rd_done          <= 1'b0;
      cmp_vld          <= 1'b0;
      cmp_idx          <= '0;
      free_found       <= 1'b0;
      free_idx         <= '0;
      tgt_idx          <= '0;
      tgt_kind         <= TGT_UPDATE;
      repl_ptr         <= '0;
      valid            <= '0;
      count            <= '0;
      bus.result_valid <= 1'b0;
      bus.result_hit   <= 1'b0;
      bus.result_port  <= '0;
    end else begin
      bus.result_valid <= 1'b0;
      if (bus.flush) begin
        // Flush wins in every state and aborts whatever is in flight.
        state      <= IDLE;
        valid      <= '0;
        count      <= '0;
        repl_ptr   <= '0;
        cmp_vld    <= 1'b0;
        rd_done    <= 1'b0;
        free_found <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (learn_acc || lookup_acc) begin
              op_learn   <= learn_acc;
              key_q      <= learn_acc ? bus.learn_key : bus.lookup_key;
              port_q     <= learn_acc ? bus.learn_port : '0;
              state      <= SCAN;
              rd_idx     <= '0;
              rd_done    <= 1'b0;
              cmp_vld    <= 1'b0;
              free_found <= 1'b0;
            end
          end
          SCAN: begin
            if (cmp_hit || scan_end) begin
              cmp_vld <= 1'b0;
              if (op_learn) begin
                state <= WRITE;
                if (cmp_hit) begin
                  tgt_idx  <= cmp_idx;
                  tgt_kind <= TGT_UPDATE;
                end else if (free_found) begin
                  tgt_idx  <= free_idx;
                  tgt_kind <= TGT_FREE;
                end else if (cur_free) begin
                  // Only the last entry was free; it was not yet recorded.
                  tgt_idx  <= cmp_idx;
                  tgt_kind <= TGT_FREE;
                end else begin
                  tgt_idx  <= repl_ptr;
                  tgt_kind <= TGT_EVICT;
                end
              end else begin
                state           <= RESPOND;
                bus.result_hit  <= cmp_hit;
                bus.result_port <= cmp_hit ? rd_port : '0;
              end
            end else begin
              if (cur_free && !free_found) begin
                free_found <= 1'b1;
                free_idx   <= cmp_idx;
              end
              // Read issued now is compared next cycle.
              cmp_vld <= !rd_done;
              cmp_idx <= rd_idx;
              if (rd_idx == LAST) rd_done <= 1'b1;
              else                rd_idx  <= rd_idx + ADDR_WIDTH'(1);
            end
          end
          WRITE: begin
            valid[tgt_idx] <= 1'b1;
            if (tgt_kind == TGT_FREE && count != FULL)
              count <= count + (ADDR_WIDTH + 1)'(1);
            // Power-of-two depth: natural wrap from DEPTH-1 to 0.
            if (tgt_kind == TGT_EVICT)
              repl_ptr <= repl_ptr + ADDR_WIDTH'(1);
            state <= IDLE;
          end
          RESPOND: begin
            bus.result_valid <= 1'b1;
            state            <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cam_table_engine.sv
// Directed bench for cam_table_engine (KEY_WIDTH=48, PORT_WIDTH=4, DEPTH=16).
module tb_cam_table_engine;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  cam_table_if #(.KEY_WIDTH(48), .PORT_WIDTH(4), .DEPTH(16)) bus ();

  cam_table_engine #(.KEY_WIDTH(48), .PORT_WIDTH(4), .DEPTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [47:0] key_of(input int i);
    return 48'h0A00_0000_0000 + 48'(i);
  endfunction

  function automatic logic [3:0] port_of(input int i);
    return 4'((i * 3 + 1) % 16);
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_learn(input string tag, input logic [47:0] k, input logic [3:0] p);
    logic done;
    bus.learn_key   = k;
    bus.learn_port  = p;
    bus.learn_valid = 1'b1;
    for (int i = 0; i < 50 && !bus.learn_ready; i++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    bus.learn_valid = 1'b0;
    for (int i = 0; i < 50 && !bus.learn_ready; i++) begin @(posedge clk); #1; end
    done = bus.learn_ready;
    if (!done) chk({tag, "_done"}, done, 1);
  endtask

  task automatic do_lookup(input logic [47:0] k, output logic seen, output logic hit,
                           output logic [3:0] port, output int lat);
    seen = 1'b0; hit = 1'b0; port = '0; lat = 0;
    bus.lookup_key   = k;
    bus.lookup_valid = 1'b1;
    for (int i = 0; i < 50 && !bus.lookup_ready; i++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    bus.lookup_valid = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.result_valid) begin
        seen = 1'b1; hit = bus.result_hit; port = bus.result_port; lat = i;
      end
    end
  endtask

  task automatic lookup_chk(input string tag, input logic [47:0] k, input logic exp_hit,
                            input logic [3:0] exp_port);
    logic seen, hit;
    logic [3:0] port;
    int lat;
    do_lookup(k, seen, hit, port, lat);
    chk({tag, "_seen"}, seen, 1);
    chk({tag, "_hit"}, hit, exp_hit);
    chk({tag, "_port"}, port, exp_port);
  endtask

  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.result_valid) n++;
    end
  endtask

  initial begin
    logic seen, hit;
    logic [3:0] port;
    int lat, npulse;
    logic [47:0] k1, k5, kx;
    n_chk = 0; n_pass = 0;
    k1 = 48'h0011_2233_4455;
    k5 = 48'h00AA_BBCC_DDEE;
    kx = 48'h0BAD_0000_0001;
    rst = 1'b1;
    bus.lookup_valid = 1'b0; bus.lookup_key = '0;
    bus.learn_valid  = 1'b0; bus.learn_key  = '0; bus.learn_port = '0;
    bus.flush        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.lookup_valid = 1'b1; bus.learn_valid = 1'b1;
    #1;
    chk("rst_lookup_ready", bus.lookup_ready, 0);
    chk("rst_learn_ready", bus.learn_ready, 0);
    chk("rst_result_valid", bus.result_valid, 0);
    chk("rst_result_hit", bus.result_hit, 0);
    chk("rst_result_port", bus.result_port, 0);
    chk("rst_entry_count", bus.entry_count, 0);
    bus.lookup_valid = 1'b0; bus.learn_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Scenario 1: lookup on empty table, full-scan latency
    do_lookup(k1, seen, hit, port, lat);
    chk("s1_seen", seen, 1);
    chk("s1_latency", 64'(lat), 18);
    chk("s1_hit", hit, 0);
    chk("s1_port", port, 0);
    chk("s1_count", bus.entry_count, 0);

    // Scenario 2: learn then hit
    do_learn("s2_learn", k1, 4'd3);
    chk("s2_count", bus.entry_count, 1);
    do_lookup(k1, seen, hit, port, lat);
    chk("s2_hit", hit, 1);
    chk("s2_port", port, 3);
    chk("s2_latency", 64'(lat), 3);

    // Scenario 3: update existing key
    do_learn("s3_learn", k1, 4'd7);
    chk("s3_count", bus.entry_count, 1);
    lookup_chk("s3", k1, 1, 4'd7);

    // Flush in IDLE: readies drop, table cleared
    bus.flush = 1'b1;
    bus.lookup_valid = 1'b1; bus.lookup_key = k1;
    #1;
    chk("fl_lookup_ready", bus.lookup_ready, 0);
    chk("fl_learn_ready", bus.learn_ready, 0);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.lookup_valid = 1'b0;
    chk("fl_count", bus.entry_count, 0);
    lookup_chk("fl_k1", k1, 0, 4'd0);

    // Scenario 4: 17 distinct keys, one eviction at entry 0
    for (int i = 0; i < 17; i++) do_learn("s4_learn", key_of(i), port_of(i));
    chk("s4_count", bus.entry_count, 16);
    lookup_chk("s4_first", key_of(0), 0, 4'd0);
    do_lookup(key_of(16), seen, hit, port, lat);
    chk("s4_k16_hit", hit, 1);
    chk("s4_k16_port", port, port_of(16));
    chk("s4_k16_latency", 64'(lat), 3);
    do_lookup(key_of(15), seen, hit, port, lat);
    chk("s4_k15_hit", hit, 1);
    chk("s4_k15_port", port, port_of(15));
    chk("s4_k15_latency", 64'(lat), 18);
    // Pointer now at 1: the next eviction must replace key 1 (entry 1)
    do_learn("s4_learn17", key_of(17), port_of(17));
    chk("s4_count17", bus.entry_count, 16);
    lookup_chk("s4_k1_evicted", key_of(1), 0, 4'd0);
    lookup_chk("s4_k2_kept", key_of(2), 1, port_of(2));
    lookup_chk("s4_k17", key_of(17), 1, port_of(17));

    // Scenario 5: learn and lookup in the same cycle (evicts entry 2)
    bus.learn_key = k5; bus.learn_port = 4'd9; bus.learn_valid = 1'b1;
    bus.lookup_key = k5; bus.lookup_valid = 1'b1;
    #1;
    chk("s5_learn_ready", bus.learn_ready, 1);
    chk("s5_lookup_ready", bus.lookup_ready, 0);
    @(posedge clk); #1;
    bus.learn_valid = 1'b0;
    seen = 1'b0; hit = 1'b0; port = '0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.result_valid) begin seen = 1'b1; hit = bus.result_hit; port = bus.result_port; end
      // lookup held until accepted; drop it on the cycle after acceptance
      if (bus.lookup_valid && bus.lookup_ready) begin @(posedge clk); #1; bus.lookup_valid = 1'b0; end
    end
    bus.lookup_valid = 1'b0;
    chk("s5_seen", seen, 1);
    chk("s5_hit", hit, 1);
    chk("s5_port", port, 9);
    chk("s5_count", bus.entry_count, 16);

    // Scenario 6: flush during a lookup scan
    bus.lookup_key = key_of(15); bus.lookup_valid = 1'b1;
    @(posedge clk); #1;
    bus.lookup_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    count_pulses(25, npulse);
    chk("s6_no_result", 64'(npulse), 0);
    chk("s6_count", bus.entry_count, 0);
    lookup_chk("s6_k15", key_of(15), 0, 4'd0);
    lookup_chk("s6_k5", k5, 0, 4'd0);

    // Reset in the middle of a scan
    do_learn("rs_learn", k1, 4'd5);
    chk("rs_count_pre", bus.entry_count, 1);
    bus.lookup_key = kx; bus.lookup_valid = 1'b1;
    @(posedge clk); #1;
    bus.lookup_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("rs_ready_low", bus.learn_ready, 0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    count_pulses(25, npulse);
    chk("rs_no_result", 64'(npulse), 0);
    chk("rs_count", bus.entry_count, 0);
    lookup_chk("rs_k1", k1, 0, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cam_table_engine.md
CAM_TABLE_ENGINE -- requirements
Module: cam_table_engine

Interface
REQ-001 Parameter KEY_WIDTH, default 48: key (MAC address) width in bits.
REQ-002 Parameter PORT_WIDTH, default 4: associated-port value width in bits.
REQ-003 Parameter DEPTH, default 16: entry count; power of two, at least 2; ADDR_WIDTH = log2(DEPTH).
REQ-004 CLK  in  1  single clock; all state updates on its rising edge.
REQ-005 RESET  in  1  reset, asynchronous, active-high.
REQ-006 lookup_valid / lookup_ready  in / out  1 / 1  lookup request handshake.
REQ-007 lookup_key  in  KEY_WIDTH  key to search.
REQ-008 learn_valid / learn_ready  in / out  1 / 1  learn request handshake.
REQ-009 learn_key / learn_port  in  KEY_WIDTH / PORT_WIDTH  entry to insert or update.
REQ-010 flush  in  1  clears all entries.
REQ-011 result_valid  out  1  one-cycle pulse completing a lookup.
REQ-012 result_hit / result_port  out  1 / PORT_WIDTH  match flag and matched port; port is 0 on a miss.
REQ-013 entry_count  out  ADDR_WIDTH+1  number of valid entries.

Function
REQ-014 Storage SHALL be a DEPTH x (KEY_WIDTH+PORT_WIDTH) array with 1-cycle registered read; valid bits SHALL be held in DEPTH flops.
REQ-015 FSM states SHALL be IDLE, SCAN, WRITE, RESPOND.
REQ-016 lookup_ready and learn_ready SHALL be high only in IDLE with flush low; a request is accepted when valid and ready are both high.
REQ-017 If both requests are valid in IDLE, learn SHALL be accepted and lookup_ready SHALL be low that cycle.
REQ-018 On acceptance, the key (and port) SHALL be captured, and the FSM SHALL move to SCAN with the read index at 0.
REQ-019 In SCAN, index i SHALL be read each cycle, and entry i SHALL be compared the following cycle, qualified by its valid bit; the scan SHALL stop at the first match or after index DEPTH-1.
REQ-020 Lookup: on a match, or at scan end, the FSM SHALL go to RESPOND and pulse result_valid for 1 cycle with hit/port; the FSM SHALL then return to IDLE; worst-case latency from acceptance to result_valid is DEPTH+2 cycles.
REQ-021 Learn target, in priority order: the matching index (port update); the lowest-index free entry recorded during the scan; the round-robin replacement pointer.
REQ-022 Learn: WRITE SHALL write the target for exactly 1 cycle, set its valid bit, and return to IDLE; no result_valid pulse is produced for a learn.
REQ-023 The replacement pointer SHALL advance by 1 and wrap from DEPTH-1 to 0 only when an eviction is performed.
REQ-024 entry_count SHALL increment on writes to free entries only; it SHALL be unchanged on updates and evictions and SHALL saturate at DEPTH.
REQ-025 flush in IDLE SHALL clear all valid bits, entry_count and the replacement pointer next cycle; requests in that cycle SHALL NOT be accepted.
REQ-026 flush outside IDLE SHALL abort the operation: all state SHALL be cleared, the FSM SHALL return to IDLE, and no result_valid pulse is produced.
REQ-027 A key matching in more than one entry cannot arise via learn; if present, the lowest index SHALL win.

Reset
REQ-028 While RESET is high: FSM SHALL be IDLE; valid bits, entry_count and the replacement pointer SHALL be 0; result_valid, result_hit and result_port SHALL be 0; both readies SHALL be 0.
REQ-029 Array contents SHALL NOT be reset; valid bits alone SHALL gate matches.
REQ-030 RESET asserted mid-scan SHALL discard the operation with no result pulse.

Structure
REQ-031 FSM state enum and default KEY_WIDTH / PORT_WIDTH / DEPTH constants SHALL reside in shared package cam_table_pkg.
REQ-032 Storage SHALL be one sub-module, cam_table_ram: a parametrised two-port RAM with 1-cycle registered read, inferable to block RAM.

Verification
REQ-033 Scenario 1: reset, then lookup key 0x001122334455 -> result_valid after 18 cycles, hit=0, port=0, entry_count=0.
REQ-034 Scenario 2: learn 0x001122334455 port 3, then lookup same key -> hit=1, port=3, entry_count=1.
REQ-035 Scenario 3: learn the same key with port 7 -> entry_count stays 1; a lookup returns port 7.
REQ-036 Scenario 4: learn 17 distinct keys (DEPTH=16) -> entry_count=16; the first-learned key misses, the 17th hits, and the replacement pointer is 1.
REQ-037 Scenario 5: assert lookup and learn in the same IDLE cycle -> learn is accepted first; the lookup is accepted after learn completes and returns the newly learned port.
REQ-038 Scenario 6: flush during SCAN of a lookup -> no result_valid, entry_count=0, and subsequent lookups of previously learned keys miss.
